// File: rtl/parity_group_ecc.sv
// rtl/parity_group_ecc.sv - group-parity encoder/decoder with optional error log
//
// Two independent one-stage pipelined channels:
//   encode: DATA_WIDTH word in -> {data, parity[NG-1:0]} codeword out
//   decode: codeword in -> data field, per-group mismatch flags out
// Parity bit g covers data[g*GROUP_WIDTH +: GROUP_WIDTH]. Even parity is the
// XOR of the group; odd parity inverts it. The decoder never corrects data.
//
// Optional feature macro: PARITY_GROUP_ECC_ERR_LOG_EN
//   defined     - saturating error counter, sticky flag and first-error group
//                 capture, all updated when an errored codeword is accepted
//   not defined - err_count/err_sticky/err_first_group tied to 0, clr_err
//                 ignored, no log registers
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enc_valid_in/enc_ready_out     encoder input handshake
//   enc_data_in                    word to encode
//   enc_valid_out/enc_ready_in     encoder output handshake
//   enc_codeword_out               {data, parity}
//   dec_valid_in/dec_ready_out     decoder input handshake
//   dec_codeword_in                {data, parity}
//   dec_valid_out/dec_ready_in     decoder output handshake
//   dec_data_out                   received data field, uncorrected
//   dec_err_groups, dec_err        per-group mismatch flags and their OR
//   clr_err                        synchronous clear of the error log
//   err_count, err_sticky,
//   err_first_group                error log outputs

module parity_group_ecc #(
    parameter int DATA_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8,
    parameter int ODD_PARITY  = 0,
    parameter int CNT_WIDTH   = 16,
    localparam int NG         = DATA_WIDTH / GROUP_WIDTH,
    localparam int GW_IDX     = (NG > 1) ? $clog2(NG) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     enc_valid_in,
    output logic                     enc_ready_out,
    input  logic [DATA_WIDTH-1:0]    enc_data_in,
    output logic                     enc_valid_out,
    input  logic                     enc_ready_in,
    output logic [DATA_WIDTH+NG-1:0] enc_codeword_out,

    input  logic                     dec_valid_in,
    output logic                     dec_ready_out,
    input  logic [DATA_WIDTH+NG-1:0] dec_codeword_in,
    output logic                     dec_valid_out,
    input  logic                     dec_ready_in,
    output logic [DATA_WIDTH-1:0]    dec_data_out,
    output logic [NG-1:0]            dec_err_groups,
    output logic                     dec_err,

    input  logic                     clr_err,
    output logic [CNT_WIDTH-1:0]     err_count,
    output logic                     err_sticky,
    output logic [GW_IDX-1:0]        err_first_group
);

    localparam int  CW_WIDTH = DATA_WIDTH + NG;
    localparam logic ODD_BIT = (ODD_PARITY != 0);

    // Parity of every group at once, already adjusted for odd/even sense.
    function automatic logic [NG-1:0] group_parity(input logic [DATA_WIDTH-1:0] data);
        logic [NG-1:0] p;
        p = '0;
        for (int g = 0; g < NG; g++) begin
            p[g] = (^data[g*GROUP_WIDTH +: GROUP_WIDTH]) ^ ODD_BIT;
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // Encode channel
    // ------------------------------------------------------------------
    logic                enc_valid_q, enc_valid_d;
    logic [CW_WIDTH-1:0] enc_codeword_q, enc_codeword_d;

    // The stage can take a word when it is empty or its word leaves this cycle.
    assign enc_ready_out = !enc_valid_q || enc_ready_in;

    always_comb begin
        enc_valid_d    = enc_valid_q;
        enc_codeword_d = enc_codeword_q;
        if (enc_ready_out) begin
            // Either refill with a new word or go empty after the transfer.
            enc_valid_d = enc_valid_in;
            if (enc_valid_in) begin
                enc_codeword_d = {enc_data_in, group_parity(enc_data_in)};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_valid_q    <= 1'b0;
            enc_codeword_q <= '0;
        end else begin
            enc_valid_q    <= enc_valid_d;
            enc_codeword_q <= enc_codeword_d;
        end
    end

    assign enc_valid_out    = enc_valid_q;
    assign enc_codeword_out = enc_codeword_q;

    // ------------------------------------------------------------------
    // Decode channel
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] dec_rx_data;
    logic [NG-1:0]         dec_rx_parity;
    logic [NG-1:0]         dec_err_in;
    logic                  dec_accept;

    assign dec_rx_data   = dec_codeword_in[CW_WIDTH-1:NG];
    assign dec_rx_parity = dec_codeword_in[NG-1:0];
    assign dec_err_in    = group_parity(dec_rx_data) ^ dec_rx_parity;

    logic                  dec_valid_q, dec_valid_d;
    logic [DATA_WIDTH-1:0] dec_data_q, dec_data_d;
    logic [NG-1:0]         dec_err_groups_q, dec_err_groups_d;

    assign dec_ready_out = !dec_valid_q || dec_ready_in;
    assign dec_accept    = dec_valid_in && dec_ready_out;

    always_comb begin
        dec_valid_d      = dec_valid_q;
        dec_data_d       = dec_data_q;
        dec_err_groups_d = dec_err_groups_q;
        if (dec_ready_out) begin
            dec_valid_d = dec_valid_in;
            if (dec_valid_in) begin
                dec_data_d       = dec_rx_data;
                dec_err_groups_d = dec_err_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_valid_q      <= 1'b0;
            dec_data_q       <= '0;
            dec_err_groups_q <= '0;
        end else begin
            dec_valid_q      <= dec_valid_d;
            dec_data_q       <= dec_data_d;
            dec_err_groups_q <= dec_err_groups_d;
        end
    end

    assign dec_valid_out  = dec_valid_q;
    assign dec_data_out   = dec_data_q;
    assign dec_err_groups = dec_err_groups_q;
    assign dec_err        = |dec_err_groups_q;

    // ------------------------------------------------------------------
    // Error log
    // ------------------------------------------------------------------
`ifdef PARITY_GROUP_ECC_ERR_LOG_EN
    logic [CNT_WIDTH-1:0] err_count_q, err_count_d;
    logic                 err_sticky_q, err_sticky_d;
    logic [GW_IDX-1:0]    err_first_group_q, err_first_group_d;
    logic [GW_IDX-1:0]    dec_low_idx;

    // Lowest set index: scan downwards so the last hit is the smallest index.
    always_comb begin
        dec_low_idx = '0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (dec_err_in[g]) begin
                dec_low_idx = GW_IDX'(g);
            end
        end
    end

    // The log is driven from the input side, so it moves on the same edge the
    // errored word enters the decoder stage rather than when it leaves.
    always_comb begin
        err_count_d       = err_count_q;
        err_sticky_d      = err_sticky_q;
        err_first_group_d = err_first_group_q;
        // Clear first so a word accepted alongside the clear is still logged.
        if (clr_err) begin
            err_count_d       = '0;
            err_sticky_d      = 1'b0;
            err_first_group_d = '0;
        end
        if (dec_accept && (|dec_err_in)) begin
            if (!err_sticky_d) begin
                err_first_group_d = dec_low_idx;
            end
            err_sticky_d = 1'b1;
            if (err_count_d != {CNT_WIDTH{1'b1}}) begin
                err_count_d = err_count_d + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q       <= '0;
            err_sticky_q      <= 1'b0;
            err_first_group_q <= '0;
        end else begin
            err_count_q       <= err_count_d;
            err_sticky_q      <= err_sticky_d;
            err_first_group_q <= err_first_group_d;
        end
    end

    assign err_count       = err_count_q;
    assign err_sticky      = err_sticky_q;
    assign err_first_group = err_first_group_q;
`else
    logic unused_log_inputs;

    assign unused_log_inputs = clr_err ^ dec_accept;
    assign err_count         = '0;
    assign err_sticky        = 1'b0;
    assign err_first_group   = '0;
`endif

endmodule

// File: tb/tb_parity_group_ecc.sv
// tb/tb_parity_group_ecc.sv - randomized self-checking bench for parity_group_ecc

module tb_parity_group_ecc;

    localparam int DW   = 32;
    localparam int GW   = 8;
    localparam int NG   = 4;
    localparam int CW   = DW + NG;
    localparam int GWI  = 2;
    localparam int CNTE = 4;
    localparam int CNTO = 16;
`ifdef PARITY_GROUP_ECC_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          enc_valid_in, enc_ready_in, dec_valid_in, dec_ready_in, clr_err;
    logic [DW-1:0] enc_data_in;
    logic [CW-1:0] dec_codeword_in;

    logic            e_enc_ready_out, e_enc_valid_out, e_dec_ready_out, e_dec_valid_out, e_dec_err, e_err_sticky;
    logic [CW-1:0]   e_enc_codeword_out;
    logic [DW-1:0]   e_dec_data_out;
    logic [NG-1:0]   e_dec_err_groups;
    logic [CNTE-1:0] e_err_count;
    logic [GWI-1:0]  e_err_first_group;

    logic            o_enc_ready_out, o_enc_valid_out, o_dec_ready_out, o_dec_valid_out, o_dec_err, o_err_sticky;
    logic [CW-1:0]   o_enc_codeword_out;
    logic [DW-1:0]   o_dec_data_out;
    logic [NG-1:0]   o_dec_err_groups;
    logic [CNTO-1:0] o_err_count;
    logic [GWI-1:0]  o_err_first_group;

    parity_group_ecc #(.DATA_WIDTH(DW), .GROUP_WIDTH(GW), .ODD_PARITY(0), .CNT_WIDTH(CNTE)) u_even (
        .clk(clk), .rst_n(rst_n),
        .enc_valid_in(enc_valid_in), .enc_ready_out(e_enc_ready_out), .enc_data_in(enc_data_in),
        .enc_valid_out(e_enc_valid_out), .enc_ready_in(enc_ready_in), .enc_codeword_out(e_enc_codeword_out),
        .dec_valid_in(dec_valid_in), .dec_ready_out(e_dec_ready_out), .dec_codeword_in(dec_codeword_in),
        .dec_valid_out(e_dec_valid_out), .dec_ready_in(dec_ready_in), .dec_data_out(e_dec_data_out),
        .dec_err_groups(e_dec_err_groups), .dec_err(e_dec_err),
        .clr_err(clr_err), .err_count(e_err_count), .err_sticky(e_err_sticky), .err_first_group(e_err_first_group)
    );

    parity_group_ecc #(.DATA_WIDTH(DW), .GROUP_WIDTH(GW), .ODD_PARITY(1), .CNT_WIDTH(CNTO)) u_odd (
        .clk(clk), .rst_n(rst_n),
        .enc_valid_in(enc_valid_in), .enc_ready_out(o_enc_ready_out), .enc_data_in(enc_data_in),
        .enc_valid_out(o_enc_valid_out), .enc_ready_in(enc_ready_in), .enc_codeword_out(o_enc_codeword_out),
        .dec_valid_in(dec_valid_in), .dec_ready_out(o_dec_ready_out), .dec_codeword_in(dec_codeword_in),
        .dec_valid_out(o_dec_valid_out), .dec_ready_in(dec_ready_in), .dec_data_out(o_dec_data_out),
        .dec_err_groups(o_dec_err_groups), .dec_err(o_dec_err),
        .clr_err(clr_err), .err_count(o_err_count), .err_sticky(o_err_sticky), .err_first_group(o_err_first_group)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference rules: count ones in each byte-group, odd count -> even-parity bit 1.
    function automatic logic [NG-1:0] exp_par(input logic [DW-1:0] d, input bit odd);
        logic [NG-1:0] p;
        logic [DW-1:0] grp;
        for (int g = 0; g < NG; g++) begin
            grp  = (d >> (g * GW)) & ((32'd1 << GW) - 1);
            p[g] = (($countones(grp) % 2) == 1) ^ odd;
        end
        return p;
    endfunction

    function automatic logic [NG-1:0] err_of(input logic [CW-1:0] cw, input bit odd);
        return exp_par(cw[CW-1:NG], odd) ^ cw[NG-1:0];
    endfunction

    function automatic int lowest(input logic [NG-1:0] e);
        for (int g = 0; g < NG; g++) if (e[g]) return g;
        return 0;
    endfunction

    // Model: each channel is a holding slot of at most one word; log per instance.
    logic [DW-1:0] enc_mq[$];
    logic [CW-1:0] dec_mq[$];
    longint        m_cnt[2];
    bit            m_sticky[2];
    int            m_first[2];
    longint        m_max[2] = '{(64'd1 << CNTE) - 1, (64'd1 << CNTO) - 1};

    always @(posedge clk or negedge rst_n) begin : model
        bit e_acc, d_acc;
        logic [NG-1:0] errs;
        if (!rst_n) begin
            enc_mq.delete();
            dec_mq.delete();
            for (int i = 0; i < 2; i++) begin
                m_cnt[i] = 0; m_sticky[i] = 0; m_first[i] = 0;
            end
        end else begin
            e_acc = enc_valid_in && (enc_mq.size() == 0 || enc_ready_in);
            d_acc = dec_valid_in && (dec_mq.size() == 0 || dec_ready_in);
            if (enc_mq.size() != 0 && enc_ready_in) void'(enc_mq.pop_front());
            if (e_acc) enc_mq.push_back(enc_data_in);
            if (dec_mq.size() != 0 && dec_ready_in) void'(dec_mq.pop_front());
            if (d_acc) dec_mq.push_back(dec_codeword_in);
            for (int i = 0; i < 2; i++) begin
                if (clr_err) begin
                    m_cnt[i] = 0; m_sticky[i] = 0; m_first[i] = 0;
                end
                errs = err_of(dec_codeword_in, i == 1);
                if (d_acc && errs != 0) begin
                    if (!m_sticky[i]) m_first[i] = lowest(errs);
                    m_sticky[i] = 1;
                    if (m_cnt[i] < m_max[i]) m_cnt[i]++;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            check("enc_valid_e", e_enc_valid_out, enc_mq.size() != 0);
            check("enc_valid_o", o_enc_valid_out, enc_mq.size() != 0);
            check("enc_ready_e", e_enc_ready_out, enc_mq.size() == 0 || enc_ready_in);
            check("enc_ready_o", o_enc_ready_out, enc_mq.size() == 0 || enc_ready_in);
            if (enc_mq.size() != 0) begin
                check("enc_cw_e", e_enc_codeword_out, {enc_mq[0], exp_par(enc_mq[0], 0)});
                check("enc_cw_o", o_enc_codeword_out, {enc_mq[0], exp_par(enc_mq[0], 1)});
            end
            check("dec_valid_e", e_dec_valid_out, dec_mq.size() != 0);
            check("dec_valid_o", o_dec_valid_out, dec_mq.size() != 0);
            check("dec_ready_e", e_dec_ready_out, dec_mq.size() == 0 || dec_ready_in);
            check("dec_ready_o", o_dec_ready_out, dec_mq.size() == 0 || dec_ready_in);
            if (dec_mq.size() != 0) begin
                check("dec_data_e", e_dec_data_out, dec_mq[0][CW-1:NG]);
                check("dec_data_o", o_dec_data_out, dec_mq[0][CW-1:NG]);
                check("dec_grp_e", e_dec_err_groups, err_of(dec_mq[0], 0));
                check("dec_grp_o", o_dec_err_groups, err_of(dec_mq[0], 1));
                check("dec_err_e", e_dec_err, err_of(dec_mq[0], 0) != 0);
                check("dec_err_o", o_dec_err, err_of(dec_mq[0], 1) != 0);
            end
            check("cnt_e", e_err_count, LOG_EN ? m_cnt[0] : 0);
            check("cnt_o", o_err_count, LOG_EN ? m_cnt[1] : 0);
            check("sticky_e", e_err_sticky, LOG_EN ? m_sticky[0] : 0);
            check("sticky_o", o_err_sticky, LOG_EN ? m_sticky[1] : 0);
            check("first_e", e_err_first_group, LOG_EN ? m_first[0] : 0);
            check("first_o", o_err_first_group, LOG_EN ? m_first[1] : 0);
        end
    end

    task automatic check_all_reset(input string tag);
        check({tag, "_enc_valid"}, e_enc_valid_out, 0);
        check({tag, "_enc_cw"}, e_enc_codeword_out, 0);
        check({tag, "_enc_ready"}, e_enc_ready_out, 1);
        check({tag, "_dec_valid"}, e_dec_valid_out, 0);
        check({tag, "_dec_data"}, e_dec_data_out, 0);
        check({tag, "_dec_grp"}, e_dec_err_groups, 0);
        check({tag, "_dec_err"}, e_dec_err, 0);
        check({tag, "_dec_ready"}, e_dec_ready_out, 1);
        check({tag, "_cnt"}, e_err_count, 0);
        check({tag, "_sticky"}, e_err_sticky, 0);
        check({tag, "_first"}, e_err_first_group, 0);
        check({tag, "_o_enc_cw"}, o_enc_codeword_out, 0);
    endtask

    function automatic logic [CW-1:0] rand_cw();
        logic [DW-1:0] d;
        logic [CW-1:0] cw;
        d  = $urandom;
        cw = {d, exp_par(d, 0)};
        if ($urandom_range(0, 2) == 0) cw = cw ^ (36'd1 << $urandom_range(0, CW - 1));
        if ($urandom_range(0, 5) == 0) cw = cw ^ (36'd1 << $urandom_range(0, CW - 1));
        return cw;
    endfunction

    task automatic run_random(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            enc_valid_in    = $urandom_range(0, 3) != 0;
            enc_data_in     = $urandom;
            enc_ready_in    = $urandom_range(0, 3) != 0;
            dec_valid_in    = $urandom_range(0, 3) != 0;
            dec_codeword_in = rand_cw();
            dec_ready_in    = $urandom_range(0, 3) != 0;
            clr_err         = $urandom_range(0, 63) == 0;
        end
        @(posedge clk); #1;
        enc_valid_in = 0; dec_valid_in = 0; clr_err = 0;
        enc_ready_in = 1; dec_ready_in = 1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [DW-1:0] wa, wb, wd;

    initial begin
        enc_valid_in = 0; enc_ready_in = 0; enc_data_in = '0;
        dec_valid_in = 0; dec_ready_in = 0; dec_codeword_in = '0; clr_err = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_reset("rst");
        rst_n = 1;

        // Model pinned to hand-computed values.
        check("model_even", exp_par(32'h01030700, 0), 4'hA);
        check("model_odd", exp_par(32'h01030700, 1), 4'h5);
        check("model_err", err_of(36'h01070700A, 0), 4'b0100);

        // Encode literal.
        @(posedge clk); #1;
        enc_valid_in = 1; enc_data_in = 32'h01030700; enc_ready_in = 1;
        @(posedge clk); #1;
        enc_valid_in = 0;
        @(negedge clk);
        check("lit_enc_valid", e_enc_valid_out, 1);
        check("lit_enc_even", e_enc_codeword_out, 36'h01030700A);
        check("lit_enc_odd", o_enc_codeword_out, 36'h010307005);

        // Decode literal with group 2 flipped.
        @(posedge clk); #1;
        dec_valid_in = 1; dec_codeword_in = 36'h01070700A; dec_ready_in = 1;
        @(posedge clk); #1;
        dec_valid_in = 0;
        @(negedge clk);
        check("lit_dec_data", e_dec_data_out, 32'h01070700);
        check("lit_dec_grp", e_dec_err_groups, 4'b0100);
        check("lit_dec_err", e_dec_err, 1);
        check("lit_cnt1", e_err_count, LOG_EN ? 1 : 0);
        check("lit_sticky1", e_err_sticky, LOG_EN ? 1 : 0);
        check("lit_first2", e_err_first_group, LOG_EN ? 2 : 0);

        // Clear, then clean / group0 / group3 words back to back.
        @(posedge clk); #1; clr_err = 1;
        @(posedge clk); #1; clr_err = 0;
        @(negedge clk);
        check("lit_clr_cnt", e_err_count, 0);
        check("lit_clr_sticky", e_err_sticky, 0);
        @(posedge clk); #1;
        dec_valid_in = 1; dec_codeword_in = 36'h01030700A;
        @(posedge clk); #1;
        dec_codeword_in = 36'h01030700B;
        @(negedge clk);
        check("lit_clean_err", e_dec_err, 0);
        @(posedge clk); #1;
        dec_codeword_in = 36'h010307002;
        @(posedge clk); #1;
        dec_valid_in = 0;
        @(negedge clk);
        check("lit_g3_grp", e_dec_err_groups, 4'b1000);
        check("lit_cnt2", e_err_count, LOG_EN ? 2 : 0);
        check("lit_first0", e_err_first_group, 0);
        check("lit_sticky2", e_err_sticky, LOG_EN ? 1 : 0);

        // Encoder backpressure with two words offered.
        wa = 32'hDEADBEEF; wb = 32'h12345678;
        @(posedge clk); #1;
        enc_ready_in = 0; enc_valid_in = 1; enc_data_in = wa;
        @(posedge clk); #1;
        enc_data_in = wb;
        @(negedge clk);
        check("bp_ready_low", e_enc_ready_out, 0);
        check("bp_hold_a1", e_enc_codeword_out[CW-1:NG], wa);
        @(posedge clk);
        @(negedge clk);
        check("bp_hold_a2", e_enc_codeword_out[CW-1:NG], wa);
        enc_ready_in = 1;
        @(posedge clk); #1;
        enc_valid_in = 0;
        @(negedge clk);
        check("bp_then_b", e_enc_codeword_out[CW-1:NG], wb);
        check("bp_b_valid", e_enc_valid_out, 1);
        @(posedge clk);
        @(negedge clk);
        check("bp_drained", e_enc_valid_out, 0);

        // Saturation of the narrow counter, then clear together with an error.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            wd = $urandom;
            dec_valid_in = 1; dec_codeword_in = {wd, exp_par(wd, 0) ^ 4'b0010};
        end
        @(posedge clk); #1;
        dec_valid_in = 0;
        @(negedge clk);
        check("sat_cnt", e_err_count, LOG_EN ? 15 : 0);
        @(posedge clk); #1;
        wd = $urandom;
        clr_err = 1; dec_valid_in = 1; dec_codeword_in = {wd, exp_par(wd, 0) ^ 4'b1000};
        @(posedge clk); #1;
        clr_err = 0; dec_valid_in = 0;
        @(negedge clk);
        check("clr_err_cnt", e_err_count, LOG_EN ? 1 : 0);
        check("clr_err_sticky", e_err_sticky, LOG_EN ? 1 : 0);
        check("clr_err_first", e_err_first_group, LOG_EN ? 3 : 0);

        run_random(1500);

        // Reset with both output stages full and stalled.
        @(posedge clk); #1;
        enc_valid_in = 1; enc_data_in = $urandom; enc_ready_in = 0;
        dec_valid_in = 1; dec_codeword_in = rand_cw() ^ 36'h1; dec_ready_in = 0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_enc_valid", e_enc_valid_out, 1);
        check("pre_rst_dec_valid", e_dec_valid_out, 1);
        #2 rst_n = 0;
        #1 check_all_reset("midrst");
        @(posedge clk); #1;
        enc_valid_in = 0; dec_valid_in = 0;
        rst_n = 1;

        run_random(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
